// File: rtl/aurora_tx_pkg.sv
// Shared types and helpers for the Aurora TX arbiter and its RX-side sibling.
package aurora_tx_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    FLUSH = 2'd2
  } arb_state_e;

  // Increment v and wrap to 0 once it reaches n.
  function automatic int unsigned mod_inc(input int unsigned v, input int unsigned n);
    return ((v + 32'd1) >= n) ? 32'd0 : (v + 32'd1);
  endfunction

endpackage

// File: rtl/aurora_rr_pick.sv
// Round-robin search: first asserted request strictly after ptr, wrapping.
module aurora_rr_pick
  import aurora_tx_pkg::*;
#(
  parameter  int NUM_SRC = 4,
  localparam int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  logic [IDX_W-1:0] cand;

  // Walk ptr+1, ptr+2, ... so the source at ptr itself is checked last.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = ptr;
    for (int i = 0; i < NUM_SRC; i++) begin
      cand = IDX_W'(mod_inc(32'(cand), NUM_SRC));
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/aurora_tx_arbiter.sv
// Frame-granular round-robin arbiter in front of the Aurora TX AXI-stream port.
// A granted source keeps the channel until its tlast beat is accepted; a frame
// cut by a channel drop is drained from its source and counted as dropped.
//
// state | meaning
// IDLE  | no owner; arbitrate among valid sources while the channel is up
// SEND  | source g owns the channel; beats pass straight through
// FLUSH | channel dropped mid-frame; accept and discard the rest of g's frame
module aurora_tx_arbiter
  import aurora_tx_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_channel_up,
  input  logic [NUM_SRC*DATA_W-1:0]   s_axi_tx_tdata,
  input  logic [NUM_SRC*DATA_W/8-1:0] s_axi_tx_tkeep,
  input  logic [NUM_SRC-1:0]          s_axi_tx_tlast,
  input  logic [NUM_SRC-1:0]          s_axi_tx_tvalid,
  output logic [NUM_SRC-1:0]          s_axi_tx_tready,
  output logic [DATA_W-1:0]           m_axi_tx_tdata,
  output logic [DATA_W/8-1:0]         m_axi_tx_tkeep,
  output logic                        m_axi_tx_tlast,
  output logic                        m_axi_tx_tvalid,
  input  logic                        m_axi_tx_tready,
  output logic [NUM_SRC-1:0]          o_grant,
  output logic                        o_busy,
  output logic [CNT_W-1:0]            o_drop_cnt
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  arb_state_e       state, state_nxt;
  logic [IDX_W-1:0] g, g_nxt;
  logic [IDX_W-1:0] p, p_nxt;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             drop_inc;
  logic [CNT_W-1:0] drop_cnt;

  logic [DATA_W-1:0]  src_data [NUM_SRC];
  logic [KEEP_W-1:0]  src_keep [NUM_SRC];
  logic [NUM_SRC-1:0] g_onehot;
  logic               sel_valid;
  logic               sel_last;

  for (genvar k = 0; k < NUM_SRC; k++) begin : gen_unpack
    assign src_data[k] = s_axi_tx_tdata[k*DATA_W +: DATA_W];
    assign src_keep[k] = s_axi_tx_tkeep[k*KEEP_W +: KEEP_W];
  end

  assign g_onehot  = NUM_SRC'(1) << g;
  assign sel_valid = s_axi_tx_tvalid[g];
  assign sel_last  = s_axi_tx_tlast[g];

  // The datapath always follows g; after reset g is 0, so source 0 is shown while idle.
  assign m_axi_tx_tdata = src_data[g];
  assign m_axi_tx_tkeep = src_keep[g];
  assign m_axi_tx_tlast = sel_last;

  assign o_grant    = (state != IDLE) ? g_onehot : '0;
  assign o_busy     = (state != IDLE);
  assign o_drop_cnt = drop_cnt;

  aurora_rr_pick #(
    .NUM_SRC (NUM_SRC)
  ) u_pick (
    .req   (s_axi_tx_tvalid),
    .ptr   (p),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Next-state, grant/pointer update and handshake outputs.
  always_comb begin
    state_nxt       = state;
    g_nxt           = g;
    p_nxt           = p;
    drop_inc        = 1'b0;
    m_axi_tx_tvalid = 1'b0;
    s_axi_tx_tready = '0;
    case (state)
      IDLE: begin
        if (i_channel_up && pick_found) begin
          g_nxt     = pick_idx;
          state_nxt = SEND;
        end
      end
      SEND: begin
        // A channel drop takes precedence over a tlast beat in the same cycle.
        if (!i_channel_up) begin
          state_nxt = FLUSH;
          drop_inc  = 1'b1;
        end else begin
          m_axi_tx_tvalid = sel_valid;
          if (m_axi_tx_tready) begin
            s_axi_tx_tready = g_onehot;
          end
          if (sel_valid && m_axi_tx_tready && sel_last) begin
            p_nxt     = g;
            state_nxt = IDLE;
          end
        end
      end
      FLUSH: begin
        s_axi_tx_tready = g_onehot;
        if (sel_valid && sel_last) begin
          p_nxt     = g;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, owner and round-robin pointer; pointer resets so source 0 wins first.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      g     <= '0;
      p     <= IDX_W'(NUM_SRC - 1);
    end else begin
      state <= state_nxt;
      g     <= g_nxt;
      p     <= p_nxt;
    end
  end

  // Saturating count of frames truncated by a channel drop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      drop_cnt <= '0;
    end else if (drop_inc && !(&drop_cnt)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_aurora_tx_arbiter.sv
// Self-checking bench: directed scenarios plus a randomized run, all compared
// each cycle against a frame-level reference model of the arbiter.
module tb_aurora_tx_arbiter;

  localparam int N        = 4;
  localparam int DW       = 32;
  localparam int KW       = DW / 8;
  localparam int CW       = 4;
  localparam int DROP_MAX = (1 << CW) - 1;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic            i_channel_up;
  logic [N*DW-1:0] s_axi_tx_tdata;
  logic [N*KW-1:0] s_axi_tx_tkeep;
  logic [N-1:0]    s_axi_tx_tlast;
  logic [N-1:0]    s_axi_tx_tvalid;
  logic [N-1:0]    s_axi_tx_tready;
  logic [DW-1:0]   m_axi_tx_tdata;
  logic [KW-1:0]   m_axi_tx_tkeep;
  logic            m_axi_tx_tlast;
  logic            m_axi_tx_tvalid;
  logic            m_axi_tx_tready;
  logic [N-1:0]    o_grant;
  logic            o_busy;
  logic [CW-1:0]   o_drop_cnt;

  always #5 i_clk = ~i_clk;

  aurora_tx_arbiter #(
    .NUM_SRC (N),
    .DATA_W  (DW),
    .CNT_W   (CW)
  ) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_channel_up    (i_channel_up),
    .s_axi_tx_tdata  (s_axi_tx_tdata),
    .s_axi_tx_tkeep  (s_axi_tx_tkeep),
    .s_axi_tx_tlast  (s_axi_tx_tlast),
    .s_axi_tx_tvalid (s_axi_tx_tvalid),
    .s_axi_tx_tready (s_axi_tx_tready),
    .m_axi_tx_tdata  (m_axi_tx_tdata),
    .m_axi_tx_tkeep  (m_axi_tx_tkeep),
    .m_axi_tx_tlast  (m_axi_tx_tlast),
    .m_axi_tx_tvalid (m_axi_tx_tvalid),
    .m_axi_tx_tready (m_axi_tx_tready),
    .o_grant         (o_grant),
    .o_busy          (o_busy),
    .o_drop_cnt      (o_drop_cnt)
  );

  // Source-side frame queues and the reference model.
  beat_t      srcq [N][$];
  bit         bubble [N];
  bit         bubble_en;
  bit         chan;
  bit         mready;
  int         own;       // owning source, -1 when nobody owns the channel
  bit         flushing;  // owner's frame is being discarded
  int         last_src;  // source that most recently finished a frame
  int         drop_m;
  logic [N-1:0] exp_ready;

  int n_cmp;
  int n_err;
  int obs_beats;
  int busy_cycles;
  int grant_log[$];
  logic [N-1:0] prev_grant;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_beat(input int s, input logic [DW-1:0] d, input logic l);
    beat_t b;
    b.d = d;
    b.k = '1;
    b.l = l;
    srcq[s].push_back(b);
  endtask

  task automatic push_frame(input int s, input int len);
    for (int i = 0; i < len; i++) begin
      beat_t b;
      b.d = $urandom;
      b.k = KW'($urandom_range(1, (1 << KW) - 1));
      b.l = (i == len - 1);
      srcq[s].push_back(b);
    end
  endtask

  task automatic reset_model();
    own      = -1;
    flushing = 1'b0;
    last_src = N - 1;
    drop_m   = 0;
    for (int k = 0; k < N; k++) begin
      srcq[k].delete();
      bubble[k] = 1'b0;
    end
  endtask

  task automatic drive_inputs();
    i_channel_up    = chan;
    m_axi_tx_tready = mready;
    for (int k = 0; k < N; k++) begin
      if (srcq[k].size() > 0 && !bubble[k]) begin
        s_axi_tx_tvalid[k]             = 1'b1;
        s_axi_tx_tdata[k*DW +: DW]     = srcq[k][0].d;
        s_axi_tx_tkeep[k*KW +: KW]     = srcq[k][0].k;
        s_axi_tx_tlast[k]              = srcq[k][0].l;
      end else begin
        s_axi_tx_tvalid[k]             = 1'b0;
        s_axi_tx_tdata[k*DW +: DW]     = '0;
        s_axi_tx_tkeep[k*KW +: KW]     = '0;
        s_axi_tx_tlast[k]              = 1'b0;
      end
    end
  endtask

  task automatic check_outputs();
    bit exp_valid;
    int gi;
    exp_ready = '0;
    exp_valid = 1'b0;
    if (own >= 0) begin
      if (!flushing) begin
        exp_valid = s_axi_tx_tvalid[own] && chan;
        if (mready && chan) exp_ready[own] = 1'b1;
      end else begin
        exp_ready[own] = 1'b1;
      end
    end
    chk("m_tvalid", m_axi_tx_tvalid, exp_valid);
    chk("s_tready", s_axi_tx_tready, exp_ready);
    chk("o_grant", o_grant, (own >= 0) ? (64'd1 << own) : 64'd0);
    chk("o_busy", o_busy, own >= 0);
    chk("o_drop_cnt", o_drop_cnt, drop_m);
    if (exp_valid) begin
      chk("m_tdata", m_axi_tx_tdata, srcq[own][0].d);
      chk("m_tkeep", m_axi_tx_tkeep, srcq[own][0].k);
      chk("m_tlast", m_axi_tx_tlast, srcq[own][0].l);
    end
    if (m_axi_tx_tvalid && m_axi_tx_tready) obs_beats++;
    if (o_busy) busy_cycles++;
    if (o_grant != '0 && o_grant != prev_grant) begin
      gi = 99;
      for (int k = 0; k < N; k++) if (o_grant[k]) gi = k;
      grant_log.push_back(gi);
    end
    prev_grant = o_grant;
  endtask

  // Frame-level behaviour: handshakes pop beats, a popped tlast ends ownership,
  // a channel loss during sending turns the rest of the frame into discards.
  task automatic advance_model();
    logic [N-1:0] v;
    bit popped_last;
    int k;
    if (i_rst) begin
      reset_model();
      return;
    end
    v = s_axi_tx_tvalid;
    popped_last = 1'b0;
    for (int s = 0; s < N; s++) bubble[s] = 1'b0;
    for (int s = 0; s < N; s++) begin
      if (v[s] && exp_ready[s]) begin
        popped_last = srcq[s][0].l;
        void'(srcq[s].pop_front());
        if (bubble_en) bubble[s] = ($urandom % 4 == 0);
      end
    end
    if (own < 0) begin
      if (chan && v != '0) begin
        for (int i = 1; i <= N; i++) begin
          k = (last_src + i) % N;
          if (v[k]) begin
            own      = k;
            flushing = 1'b0;
            break;
          end
        end
      end
    end else if (popped_last) begin
      last_src = own;
      own      = -1;
      flushing = 1'b0;
    end else if (!flushing && !chan) begin
      flushing = 1'b1;
      if (drop_m < DROP_MAX) drop_m++;
    end
  endtask

  task automatic step();
    drive_inputs();
    @(negedge i_clk);
    check_outputs();
    @(posedge i_clk);
    advance_model();
    #1;
  endtask

  function automatic int pending();
    int t = 0;
    for (int k = 0; k < N; k++) t += srcq[k].size();
    return t;
  endfunction

  initial begin
    int rr_exp[5];
    int down_left;
    int guard;
    rr_exp     = '{0, 1, 2, 3, 0};
    n_cmp      = 0;
    n_err      = 0;
    obs_beats  = 0;
    busy_cycles = 0;
    prev_grant = '0;
    bubble_en  = 1'b0;
    chan       = 1'b0;
    mready     = 1'b0;
    reset_model();
    i_rst = 1'b1;
    drive_inputs();
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    reset_model();

    // Reset state with no traffic.
    step();

    // Single source, three beats, channel up, ready held.
    chan = 1'b1;
    mready = 1'b1;
    push_beat(0, 32'hA0, 1'b0);
    push_beat(0, 32'hA1, 1'b0);
    push_beat(0, 32'hA2, 1'b1);
    obs_beats = 0;
    repeat (6) step();
    chk("single_beats", obs_beats, 3);

    // Reset in the middle of a frame from source 3.
    push_frame(3, 4);
    step();
    step();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    chk("rst_mid_busy", o_busy, 0);
    chk("rst_mid_grant", o_grant, 0);
    chk("rst_mid_drop", o_drop_cnt, 0);
    repeat (2) step();

    // Round-robin among four continuously requesting sources.
    grant_log.delete();
    push_frame(0, 2);
    push_frame(0, 2);
    for (int s = 1; s < N; s++) push_frame(s, 2);
    repeat (20) step();
    chk("rr_count", grant_log.size(), 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("rr_order%0d", i), (i < grant_log.size()) ? grant_log[i] : 99, rr_exp[i]);

    // Backpressure: ready toggles every cycle during a 4-beat frame from source 2.
    push_frame(2, 4);
    busy_cycles = 0;
    for (int t = 0; t < 12; t++) begin
      mready = (t % 2 == 0);
      step();
    end
    chk("bp_busy_cycles", busy_cycles, 8);
    mready = 1'b1;

    // Channel drop after two beats of a 5-beat frame from source 1.
    grant_log.delete();
    obs_beats = 0;
    push_frame(1, 5);
    step();
    push_frame(2, 2);
    step();
    step();
    chan = 1'b0;
    repeat (5) step();
    chan = 1'b1;
    repeat (5) step();
    chk("drop_cnt_one", o_drop_cnt, 1);
    chk("drop_beats", obs_beats, 4);
    chk("drop_first_owner", (grant_log.size() > 0) ? grant_log[0] : 99, 1);
    chk("drop_next_owner", (grant_log.size() > 1) ? grant_log[1] : 99, 2);

    // Channel down while idle: no grant until it comes back.
    chan = 1'b0;
    push_frame(0, 2);
    repeat (5) step();
    chk("down_idle_grant", o_grant, 0);
    chk("down_idle_ready", s_axi_tx_tready, 0);
    chan = 1'b1;
    step();
    chk("up_grant", o_grant, 4'b0001);
    repeat (4) step();

    // Randomized traffic, channel drops and backpressure.
    bubble_en = 1'b1;
    down_left = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int s = 0; s < N; s++)
        if (srcq[s].size() == 0 && $urandom % 8 == 0) push_frame(s, $urandom_range(1, 6));
      if (down_left > 0) begin
        chan = 1'b0;
        down_left--;
      end else if ($urandom % 25 == 0) begin
        chan = 1'b0;
        down_left = $urandom_range(0, 5);
      end else begin
        chan = 1'b1;
      end
      mready = ($urandom % 4 != 0);
      step();
    end

    // Drain with the channel up and ready held.
    bubble_en = 1'b0;
    chan = 1'b1;
    mready = 1'b1;
    guard = 0;
    while ((pending() > 0 || own >= 0) && guard < 500) begin
      step();
      guard++;
    end
    chk("drain_done", pending(), 0);
    step();
    chk("drop_sat", o_drop_cnt, DROP_MAX);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
